// File: rtl/trace_pkg.sv
// Shared types for the trace capture block: FSM state encoding and the
// buffered snapshot entry {last, iter, state}.
package trace_pkg;

    localparam int unsigned TRACE_STATE_W = 64;
    localparam int unsigned TRACE_ITER_W  = 10;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DRAIN,
        DONE
    } trace_state_e;

    typedef struct packed {
        logic                     last;
        logic [TRACE_ITER_W-1:0]  iter;
        logic [TRACE_STATE_W-1:0] state;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace entries; pointers carry an extra wrap bit so
// full/empty are distinguished without a separate counter.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  trace_entry_t               wdata,
    output trace_entry_t               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = 1;

    trace_entry_t    mem_q [DEPTH];
    logic [AW:0]     wptr_q;
    logic [AW:0]     rptr_q;
    logic            wr_en;
    logic            rd_en;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count = wptr_q - rptr_q;
    assign rdata = mem_q[rptr_q[AW-1:0]];

    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + PtrOne;
            if (rd_en) rptr_q <= rptr_q + PtrOne;
        end
    end

    // Storage is reset so the head outputs are never X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en && !flush) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/trace_capture.sv
// Samples network_state on each iteration advance into a FIFO streamed over
// valid/ready; define TRACE_CHANGE_ONLY_EN to skip pushes of unchanged state.
module trace_capture
    import trace_pkg::*;
#(
    parameter int unsigned STATE_W = TRACE_STATE_W,
    parameter int unsigned ITER_W  = TRACE_ITER_W,
    parameter int unsigned DEPTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [STATE_W-1:0]         network_state,
    input  logic [ITER_W-1:0]          iteration_number,
    input  logic                       steady_state,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [STATE_W-1:0]         out_state,
    output logic [ITER_W-1:0]          out_iter,
    output logic                       out_last,
    output logic [$clog2(DEPTH):0]     fill,
    output logic                       overflow,
    output logic                       done
);

    trace_state_e        state_q, state_d;
    logic [ITER_W-1:0]   prev_iter_q, prev_iter_d;
    logic                overflow_q, overflow_d;

    logic                push_req;
    logic                push_last;
    logic                pop;
    logic                full;
    logic                empty;
    logic                iter_chg;
    logic                filter_ok;
    trace_entry_t        wdata;
    trace_entry_t        head;

    assign iter_chg  = (iteration_number != prev_iter_q);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign wdata     = '{last: push_last, iter: iteration_number, state: network_state};

`ifdef TRACE_CHANGE_ONLY_EN
    logic [STATE_W-1:0] last_pushed_q;
    logic               push_accept;

    assign push_accept = push_req && (!full || pop);
    assign filter_ok   = (network_state != last_pushed_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_pushed_q <= '0;
        end else if (start) begin
            last_pushed_q <= '0;
        end else if (push_accept) begin
            last_pushed_q <= network_state;
        end
    end
`else
    assign filter_ok = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        prev_iter_d = prev_iter_q;
        overflow_d  = overflow_q;
        push_req    = 1'b0;
        push_last   = 1'b0;
        if (start) begin
            overflow_d  = 1'b0;
            prev_iter_d = iteration_number;
            state_d     = ARMED;
        end else begin
            case (state_q)
                ARMED, CAPTURE: begin
                    if (iter_chg) prev_iter_d = iteration_number;
                    // The steady-state entry overrides an ordinary push and is never filtered.
                    if (state_q == CAPTURE && steady_state) begin
                        push_req  = 1'b1;
                        push_last = 1'b1;
                        state_d   = DRAIN;
                    end else if (iter_chg) begin
                        push_req = filter_ok;
                        if (state_q == ARMED) state_d = CAPTURE;
                    end
                end
                DRAIN: begin
                    if (pop && out_last) state_d = DONE;
                end
                default: ;
            endcase
            if (push_req && full && !pop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            prev_iter_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_iter_q <= prev_iter_d;
            overflow_q  <= overflow_d;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (start),
        .push  (push_req),
        .pop   (pop),
        .wdata (wdata),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fill)
    );

    assign out_state = head.state;
    assign out_iter  = head.iter;
    assign out_last  = head.last;
    assign overflow  = overflow_q;
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_trace_capture.sv
// Directed and randomized bench for trace_capture against a queue-based
// reference model; honours TRACE_CHANGE_ONLY_EN when defined.
module tb_trace_capture;

    localparam int DEPTH = 16;
    localparam int MIdle = 0, MArmed = 1, MCapture = 2, MDrain = 3, MDone = 4;

    typedef struct {
        bit        last;
        bit [9:0]  iter;
        bit [63:0] state;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] network_state;
    logic [9:0]  iteration_number;
    logic        steady_state;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_state;
    logic [9:0]  out_iter;
    logic        out_last;
    logic [4:0]  fill;
    logic        overflow;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    snap_t     q[$];
    int        m_mode;
    bit [9:0]  m_prev;
    bit        m_ovf;
    bit [63:0] m_lps;

    always #5 clk = ~clk;

    trace_capture #(
        .STATE_W (64),
        .ITER_W  (10),
        .DEPTH   (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .network_state    (network_state),
        .iteration_number (iteration_number),
        .steady_state     (steady_state),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_state        (out_state),
        .out_iter         (out_iter),
        .out_last         (out_last),
        .fill             (fill),
        .overflow         (overflow),
        .done             (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'(q.size() != 0));
        check({tag, "_fill"}, 64'(fill), 64'(q.size()));
        check({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
        check({tag, "_done"}, 64'(done), 64'(m_mode == MDone));
        if (q.size() != 0) begin
            check({tag, "_iter"}, 64'(out_iter), 64'(q[0].iter));
            check({tag, "_state"}, out_state, q[0].state);
            check({tag, "_last"}, 64'(out_last), 64'(q[0].last));
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_mode = MIdle;
        m_prev = '0;
        m_ovf  = 1'b0;
        m_lps  = '0;
    endtask

    // One clock of spec behaviour, evaluated on the inputs present before the edge.
    task automatic model_step();
        bit pop, popped_last, full_pre, req, lastb, chg;
        if (start) begin
            q.delete();
            m_ovf  = 1'b0;
            m_prev = iteration_number;
            m_lps  = '0;
            m_mode = MArmed;
            return;
        end
        pop         = (q.size() != 0) && out_ready;
        popped_last = pop && q[0].last;
        full_pre    = (q.size() == DEPTH);
        chg         = (iteration_number != m_prev);
        req         = 1'b0;
        lastb       = 1'b0;
        if (m_mode == MDrain && popped_last) m_mode = MDone;
        if (m_mode == MArmed || m_mode == MCapture) begin
            if (m_mode == MCapture && steady_state) begin
                req    = 1'b1;
                lastb  = 1'b1;
                m_mode = MDrain;
            end else if (chg) begin
`ifdef TRACE_CHANGE_ONLY_EN
                req = (network_state != m_lps);
`else
                req = 1'b1;
`endif
                if (m_mode == MArmed) m_mode = MCapture;
            end
            if (chg) m_prev = iteration_number;
        end
        if (pop) void'(q.pop_front());
        if (req) begin
            if (!full_pre || pop) begin
                q.push_back('{last: lastb, iter: iteration_number, state: network_state});
                m_lps = network_state;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic cycle(input string tag);
        if (!rst) model_reset();
        else model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic pulse_start(input logic [9:0] it);
        iteration_number = it;
        start = 1'b1;
        cycle("start");
        start = 1'b0;
    endtask

    task automatic advance(input string tag, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            iteration_number = iteration_number + 10'd1;
            network_state = {$urandom, $urandom};
            cycle(tag);
            for (int g = 1; g < gap; g++) cycle(tag);
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        network_state = '0;
        iteration_number = '0;
        steady_state = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        check("reset_out_iter", 64'(out_iter), 64'd0);
        check("reset_out_state", out_state, 64'd0);
        check("reset_out_last", 64'(out_last), 64'd0);
        cycle("reset");
        rst = 1'b1;
        cycle("idle");

        // Slow advance, reader always ready.
        pulse_start(10'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            advance("slow", 1, 2);
            check("slow_fill_le1", 64'(fill <= 5'd1), 64'd1);
        end

        // Reader stalled: fill to DEPTH, overflow, then drain in order.
        pulse_start(10'd0);
        out_ready = 1'b0;
        advance("stall", 20, 1);
        check("stall_fill", 64'(fill), 64'd16);
        check("stall_ovf", 64'(overflow), 64'd1);
        check("stall_head", 64'(out_iter), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) cycle("drain16");

        // Steady state at iteration 7.
        pulse_start(10'd0);
        out_ready = 1'b1;
        advance("steady", 6, 1);
        iteration_number = 10'd7;
        network_state = {$urandom, $urandom};
        steady_state = 1'b1;
        cycle("steady7");
        check("steady7_last", 64'(out_last), 64'd1);
        check("steady7_iter", 64'(out_iter), 64'd7);
        cycle("steady_pop");
        steady_state = 1'b0;
        check("steady_done", 64'(done), 64'd1);
        cycle("steady_hold");
        pulse_start(iteration_number);
        check("start_clears_done", 64'(done), 64'd0);

        // Iteration wrap 1023 -> 0.
        pulse_start(10'd1022);
        out_ready = 1'b0;
        advance("wrap", 2, 1);
        check("wrap_fill", 64'(fill), 64'd2);
        check("wrap_head", 64'(out_iter), 64'd1023);
        out_ready = 1'b1;
        cycle("wrap_pop");
        check("wrap_second", 64'(out_iter), 64'd0);
        cycle("wrap_empty");

        // Last entry dropped by a full FIFO: DRAIN never reaches DONE.
        pulse_start(10'd0);
        out_ready = 1'b0;
        advance("lastdrop", 16, 1);
        iteration_number = iteration_number + 10'd1;
        steady_state = 1'b1;
        cycle("lastdrop_push");
        steady_state = 1'b0;
        check("lastdrop_ovf", 64'(overflow), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) cycle("lastdrop_drain");
        check("lastdrop_no_done", 64'(done), 64'd0);

        // Asynchronous reset mid-DRAIN with five entries buffered.
        pulse_start(10'd0);
        out_ready = 1'b0;
        advance("rstdrain", 4, 1);
        iteration_number = iteration_number + 10'd1;
        steady_state = 1'b1;
        cycle("rstdrain_last");
        steady_state = 1'b0;
        check("rstdrain_fill5", 64'(fill), 64'd5);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_async_valid", 64'(out_valid), 64'd0);
        check("rst_async_fill", 64'(fill), 64'd0);
        advance("in_reset", 2, 1);
        rst = 1'b1;
        out_ready = 1'b1;
        advance("idle_ignores", 3, 1);
        check("idle_no_push", 64'(out_valid), 64'd0);

        // start mid-capture clears FIFO and overflow.
        pulse_start(10'd0);
        out_ready = 1'b0;
        advance("midcap", 18, 1);
        check("midcap_ovf", 64'(overflow), 64'd1);
        pulse_start(iteration_number);
        check("midcap_flush_fill", 64'(fill), 64'd0);
        check("midcap_flush_ovf", 64'(overflow), 64'd0);

`ifdef TRACE_CHANGE_ONLY_EN
        begin
            logic [63:0] pat [5];
            pat[0] = 64'hA; pat[1] = 64'hA; pat[2] = 64'hB; pat[3] = 64'hB; pat[4] = 64'hA;
            pulse_start(10'd0);
            out_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                iteration_number = iteration_number + 10'd1;
                network_state = pat[i];
                cycle("chg_only");
            end
            check("chg_only_fill", 64'(fill), 64'd3);
            out_ready = 1'b1;
            for (int i = 0; i < 4; i++) cycle("chg_only_drain");
        end
`endif

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 79) == 0);
            steady_state = ($urandom_range(0, 29) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 1) == 1) begin
                iteration_number = ($urandom_range(0, 7) == 0) ?
                    10'($urandom) : iteration_number + 10'd1;
                network_state = ($urandom_range(0, 3) == 0) ? network_state : {$urandom, $urandom};
            end
            cycle("rand");
        end
        start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
